// File: rtl/keycode_pkg.sv
// Shared HID keycode constants and jump FSM state encoding
// for the keyboard-driven player action controller.
package keycode_pkg;

    localparam logic [7:0] HID_KEY_NONE = 8'h00;
    localparam logic [7:0] HID_KEY_A    = 8'h04;
    localparam logic [7:0] HID_KEY_D    = 8'h07;
    localparam logic [7:0] HID_KEY_W    = 8'h1A;

    typedef enum logic [1:0] {
        JUMP_IDLE,
        JUMP_REQ,
        JUMP_HELD
    } jump_state_t;

endpackage

// File: rtl/keycode_debounce.sv
// Samples the raw keycode and accepts it once it has held
// steady for STABLE_FRAMES frame ticks.
module keycode_debounce #(
    parameter int unsigned STABLE_FRAMES = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] keycode,
    input  logic       frame_tick,
    output logic [7:0] stable_code,
    output logic       key_changed
);

    localparam int unsigned CW = $clog2(STABLE_FRAMES + 1);
    localparam logic [CW-1:0] SAT = CW'(STABLE_FRAMES);

    logic [7:0]    sample_q;
    logic [7:0]    candidate_q;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_inc;

    assign count_inc = count_q + 1'b1;

    // A sample change wins over a coincident tick: the tick is dropped.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sample_q    <= '0;
            candidate_q <= '0;
            count_q     <= '0;
            stable_code <= '0;
            key_changed <= 1'b0;
        end else begin
            sample_q    <= keycode;
            key_changed <= 1'b0;
            if (sample_q != candidate_q) begin
                candidate_q <= sample_q;
                count_q     <= '0;
            end else if (frame_tick && (count_q != SAT)) begin
                count_q <= count_inc;
                if (count_inc == SAT) begin
                    stable_code <= candidate_q;
                    key_changed <= (candidate_q != stable_code);
                end
            end
        end
    end

endmodule

// File: rtl/keycode_action_ctrl.sv
// Turns debounced keycodes into move levels and a jump
// request that is held until the player logic acknowledges it.
module keycode_action_ctrl
    import keycode_pkg::*;
#(
    parameter int unsigned STABLE_FRAMES = 2,
    parameter logic [7:0]  KEY_LEFT      = HID_KEY_A,
    parameter logic [7:0]  KEY_RIGHT     = HID_KEY_D,
    parameter logic [7:0]  KEY_JUMP      = HID_KEY_W
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] keycode,
    input  logic       frame_tick,
    input  logic       jump_ack,
    output logic [7:0] stable_code,
    output logic       key_changed,
    output logic       move_left,
    output logic       move_right,
    output logic       jump_req
);

    jump_state_t state_q;
    jump_state_t state_d;
    logic        is_jump;

    keycode_debounce #(
        .STABLE_FRAMES(STABLE_FRAMES)
    ) u_debounce (
        .clk        (clk),
        .reset_n    (reset_n),
        .keycode    (keycode),
        .frame_tick (frame_tick),
        .stable_code(stable_code),
        .key_changed(key_changed)
    );

    assign is_jump  = (stable_code == KEY_JUMP);
    assign jump_req = (state_q == JUMP_REQ);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            move_left  <= 1'b0;
            move_right <= 1'b0;
            state_q    <= JUMP_IDLE;
        end else begin
            move_left  <= (stable_code == KEY_LEFT);
            move_right <= (stable_code == KEY_RIGHT);
            state_q    <= state_d;
        end
    end

    // Ack beats release in REQ so a late ack is never lost.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            JUMP_IDLE: if (is_jump) state_d = JUMP_REQ;
            JUMP_REQ: begin
                if (jump_ack)     state_d = JUMP_HELD;
                else if (!is_jump) state_d = JUMP_IDLE;
            end
            JUMP_HELD: if (!is_jump) state_d = JUMP_IDLE;
            default: state_d = JUMP_IDLE;
        endcase
    end

endmodule

// File: tb/tb_keycode_action_ctrl.sv
// Scoreboard bench: stimulus queues expected output changes
// with their cycle; a negedge monitor pops and compares them.
module tb_keycode_action_ctrl;
    import keycode_pkg::*;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] keycode;
    logic       frame_tick;
    logic       jump_ack;
    logic [7:0] stable_code;
    logic       key_changed;
    logic       move_left;
    logic       move_right;
    logic       jump_req;

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;

    typedef struct {
        int          c;
        logic [11:0] v;
    } exp_t;

    exp_t        q[$];
    exp_t        e;
    logic [11:0] cur_v;
    logic [11:0] prev_v = '0;

    keycode_action_ctrl #(
        .STABLE_FRAMES(2)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .keycode    (keycode),
        .frame_tick (frame_tick),
        .jump_ack   (jump_ack),
        .stable_code(stable_code),
        .key_changed(key_changed),
        .move_left  (move_left),
        .move_right (move_right),
        .jump_req   (jump_req)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign cur_v = {stable_code, key_changed, move_left, move_right, jump_req};

    function automatic logic [11:0] vec(input logic [7:0] s, input logic kc,
                                        input logic ml, input logic mr,
                                        input logic jr);
        return {s, kc, ml, mr, jr};
    endfunction

    // Monitor: every change of the output bundle must match the next expectation.
    always @(negedge clk) begin
        if (cur_v !== prev_v) begin
            checks++;
            if (q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_change cyc=%0d got=%h required no change",
                         cyc, cur_v);
            end else begin
                e = q.pop_front();
                if (e.c != cyc || e.v !== cur_v) begin
                    fails++;
                    $display("FAIL event: got cyc %0d out %h, required cyc %0d out %h",
                             cyc, cur_v, e.c, e.v);
                end
            end
        end
        prev_v = cur_v;
    end

    task automatic expect_at(input int c, input logic [11:0] v);
        exp_t x;
        x.c = c;
        x.v = v;
        q.push_back(x);
    endtask

    task automatic check(input string name, input logic [11:0] got,
                         input logic [11:0] req);
        checks++;
        if (got !== req) begin
            fails++;
            $display("FAIL %s: got %h required %h", name, got, req);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic pulse_tick();
        frame_tick = 1'b1;
        idle(1);
        frame_tick = 1'b0;
    endtask

    task automatic settle(input logic [7:0] code);
        keycode = code;
        idle(3);
        pulse_tick();
        idle(9);
        pulse_tick();
    endtask

    task automatic qualify(input logic [7:0] code, input logic [11:0] e0,
                           input logic [11:0] e1);
        settle(code);
        expect_at(cyc, e0);
        expect_at(cyc + 1, e1);
    endtask

    initial begin
        reset_n    = 1'b0;
        keycode    = 8'h00;
        frame_tick = 1'b0;
        jump_ack   = 1'b0;
        #1;
        check("reset_outputs", cur_v, 12'h000);
        idle(3);
        reset_n = 1'b1;

        // Left key held: accept on 2nd tick, move_left a cycle later
        qualify(8'h04, vec(8'h04, 1, 0, 0, 0), vec(8'h04, 0, 1, 0, 0));
        idle(3);
        pulse_tick();
        idle(3);
        pulse_tick();
        idle(3);

        // Release, then bounce between D and none each tick
        qualify(8'h00, vec(8'h00, 1, 1, 0, 0), vec(8'h00, 0, 0, 0, 0));
        for (int i = 0; i < 6; i++) begin
            keycode = (i % 2 == 0) ? 8'h07 : 8'h00;
            idle(3);
            pulse_tick();
        end
        pulse_tick();
        idle(3);
        check("bounce_outputs", cur_v, vec(8'h00, 0, 0, 0, 0));

        // Jump held, acked, no repeat while held
        qualify(8'h1A, vec(8'h1A, 1, 0, 0, 0), vec(8'h1A, 0, 0, 0, 1));
        idle(3);
        jump_ack = 1'b1;
        idle(1);
        jump_ack = 1'b0;
        expect_at(cyc, vec(8'h1A, 0, 0, 0, 0));
        idle(3);
        pulse_tick();
        idle(5);
        pulse_tick();
        idle(5);
        check("held_state", 12'(dut.state_q), 12'(JUMP_HELD));
        qualify(8'h00, vec(8'h00, 1, 0, 0, 0), vec(8'h00, 0, 0, 0, 0));
        qualify(8'h1A, vec(8'h1A, 1, 0, 0, 0), vec(8'h1A, 0, 0, 0, 1));
        idle(3);

        // Release before ack cancels the request
        qualify(8'h00, vec(8'h00, 1, 0, 0, 1), vec(8'h00, 0, 0, 0, 0));
        qualify(8'h1A, vec(8'h1A, 1, 0, 0, 0), vec(8'h1A, 0, 0, 0, 1));
        idle(3);

        // Ack on the same cycle the release is seen goes to HELD
        settle(8'h00);
        jump_ack = 1'b1;
        expect_at(cyc, vec(8'h00, 1, 0, 0, 1));
        expect_at(cyc + 1, vec(8'h00, 0, 0, 0, 0));
        idle(1);
        jump_ack = 1'b0;
        check("ack_release_held", 12'(dut.state_q), 12'(JUMP_HELD));
        idle(1);
        check("held_to_idle", 12'(dut.state_q), 12'(JUMP_IDLE));

        // Ack while idle does nothing
        jump_ack = 1'b1;
        idle(2);
        jump_ack = 1'b0;
        idle(1);
        check("idle_ack_ignored", 12'(dut.state_q), 12'(JUMP_IDLE));

        // Change coincident with a tick: that tick is discarded
        keycode = 8'h07;
        idle(1);
        pulse_tick();
        idle(9);
        pulse_tick();
        idle(9);
        pulse_tick();
        expect_at(cyc, vec(8'h07, 1, 0, 0, 0));
        expect_at(cyc + 1, vec(8'h07, 0, 0, 1, 0));
        idle(3);

        // Async reset during an outstanding jump request
        qualify(8'h1A, vec(8'h1A, 1, 0, 1, 0), vec(8'h1A, 0, 0, 0, 1));
        idle(3);
        reset_n = 1'b0;
        expect_at(cyc, 12'h000);
        #1;
        check("async_reset", cur_v, 12'h000);
        idle(3);
        reset_n = 1'b1;
        idle(2);
        pulse_tick();
        idle(9);
        pulse_tick();
        expect_at(cyc, vec(8'h1A, 1, 0, 0, 0));
        expect_at(cyc + 1, vec(8'h1A, 0, 0, 0, 1));
        idle(5);

        check("queue_drained", 12'(q.size()), 12'h000);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

endmodule
